// File: rtl/pixel_stacker.sv
// Packs 8 horizontally consecutive RGB565 pixels into one 128-bit burst word
// with its burst address, presented on an AXI-stream-style master.
module pixel_stacker #(
   parameter int                    H_ACTIVE   = 1280,
   parameter int                    V_ACTIVE   = 720,
   parameter int                    ADDR_WIDTH = 24,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
   parameter int                    DROP_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  pixel_tvalid,
   output logic                  pixel_tready,
   input  logic [15:0]           pixel_tdata,
   input  logic [10:0]           pixel_h_count,
   input  logic [9:0]            pixel_v_count,
   output logic                  chunk_tvalid,
   input  logic                  chunk_tready,
   output logic [127:0]          chunk_tdata,
   output logic [ADDR_WIDTH-1:0] chunk_taddr,
   output logic                  chunk_tlast,
   output logic [DROP_WIDTH-1:0] drop_count
);

   // state | meaning
   // IDLE  | fill index 0, no chunk in progress
   // FILL  | 1..7 pixels held in the pack buffer
   // HOLD  | 8 pixels held, output register occupied; input stalled
   typedef enum logic [1:0] {IDLE, FILL, HOLD} state_t;

   localparam logic [10:0] H_MAX  = 11'(H_ACTIVE);
   localparam logic [9:0]  V_MAX  = 10'(V_ACTIVE);
   localparam logic [10:0] H_LAST = 11'(H_ACTIVE - 1);
   localparam logic [9:0]  V_LAST = 10'(V_ACTIVE - 1);

   state_t                state;
   logic [127:0]          pack_buf;
   logic [2:0]            fill_idx;
   logic [ADDR_WIDTH-1:0] start_addr;
   logic [10:0]           exp_h;
   logic [9:0]            exp_v;
   logic                  hold_last;

   logic                  accept;
   logic                  in_seq;
   logic                  can_start;
   logic                  out_free;
   logic                  full_last;
   logic [20:0]           lin_pos;
   logic [ADDR_WIDTH-1:0] pix_addr;
   logic [127:0]          full_word;
   logic [3:0]            drop_add;
   logic [DROP_WIDTH:0]   drop_sum;

   assign pixel_tready = !rst && (state != HOLD);
   assign accept       = pixel_tvalid && pixel_tready;
   assign in_seq       = (state == FILL) && (pixel_h_count == exp_h) && (pixel_v_count == exp_v);
   assign can_start    = (pixel_h_count < H_MAX) && (pixel_v_count < V_MAX) &&
                         (pixel_h_count[2:0] == 3'd0);
   assign out_free     = !chunk_tvalid || chunk_tready;
   assign full_last    = (pixel_h_count == H_LAST) && (pixel_v_count == V_LAST);
   assign lin_pos      = 21'(pixel_v_count) * 21'(H_ACTIVE) + 21'(pixel_h_count);
   assign pix_addr     = BASE_ADDR + ADDR_WIDTH'(lin_pos[20:3]);
   assign full_word    = {pixel_tdata, pack_buf[111:0]};

   // A broken sequence discards every held pixel, plus the new one if it cannot start a chunk.
   always_comb begin
      drop_add = 4'd0;
      if (accept && !in_seq) begin
         drop_add = ((state == FILL) ? {1'b0, fill_idx} : 4'd0) + (can_start ? 4'd0 : 4'd1);
      end
   end

   assign drop_sum = {1'b0, drop_count} + (DROP_WIDTH+1)'(drop_add);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         pack_buf     <= '0;
         fill_idx     <= 3'd0;
         start_addr   <= '0;
         exp_h        <= 11'd0;
         exp_v        <= 10'd0;
         hold_last    <= 1'b0;
         chunk_tvalid <= 1'b0;
         chunk_tdata  <= '0;
         chunk_taddr  <= '0;
         chunk_tlast  <= 1'b0;
         drop_count   <= '0;
      end else begin
         drop_count <= drop_sum[DROP_WIDTH] ? '1 : drop_sum[DROP_WIDTH-1:0];
         if (chunk_tvalid && chunk_tready)
            chunk_tvalid <= 1'b0;

         case (state)
            HOLD: begin
               if (chunk_tvalid && chunk_tready) begin
                  chunk_tvalid <= 1'b1;
                  chunk_tdata  <= pack_buf;
                  chunk_taddr  <= start_addr;
                  chunk_tlast  <= hold_last;
                  fill_idx     <= 3'd0;
                  state        <= IDLE;
               end
            end
            default: begin
               if (accept) begin
                  if (in_seq) begin
                     pack_buf[{fill_idx, 4'b0000} +: 16] <= pixel_tdata;
                     exp_h <= exp_h + 11'd1;
                     if (fill_idx == 3'd7) begin
                        fill_idx <= 3'd0;
                        if (out_free) begin
                           chunk_tvalid <= 1'b1;
                           chunk_tdata  <= full_word;
                           chunk_taddr  <= start_addr;
                           chunk_tlast  <= full_last;
                           state        <= IDLE;
                        end else begin
                           hold_last <= full_last;
                           state     <= HOLD;
                        end
                     end else begin
                        fill_idx <= fill_idx + 3'd1;
                     end
                  end else if (can_start) begin
                     pack_buf[15:0] <= pixel_tdata;
                     fill_idx       <= 3'd1;
                     start_addr     <= pix_addr;
                     exp_h          <= pixel_h_count + 11'd1;
                     exp_v          <= pixel_v_count;
                     state          <= FILL;
                  end else begin
                     fill_idx <= 3'd0;
                     state    <= IDLE;
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pixel_stacker.sv
// Self-checking bench for pixel_stacker: directed scenarios plus a randomized
// stream, all scored against a queue-based reference model of the packing rules.
module tb_pixel_stacker;
   localparam int H = 1280;
   localparam int V = 720;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         pixel_tvalid = 1'b0;
   logic         pixel_tready;
   logic [15:0]  pixel_tdata = '0;
   logic [10:0]  pixel_h_count = '0;
   logic [9:0]   pixel_v_count = '0;
   logic         chunk_tvalid;
   logic         chunk_tready = 1'b1;
   logic [127:0] chunk_tdata;
   logic [23:0]  chunk_taddr;
   logic         chunk_tlast;
   logic [15:0]  drop_count;

   pixel_stacker dut (
      .clk(clk), .rst(rst),
      .pixel_tvalid(pixel_tvalid), .pixel_tready(pixel_tready), .pixel_tdata(pixel_tdata),
      .pixel_h_count(pixel_h_count), .pixel_v_count(pixel_v_count),
      .chunk_tvalid(chunk_tvalid), .chunk_tready(chunk_tready), .chunk_tdata(chunk_tdata),
      .chunk_taddr(chunk_taddr), .chunk_tlast(chunk_tlast), .drop_count(drop_count)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int n_out    = 0;
   int last_tries = 0;
   bit rand_ready = 0;

   // Reference model: the current run of consecutive pixels and the expected chunks.
   logic [15:0]  run_d[$];
   int           run_start_h, run_last_h, run_v;
   int           m_drops = 0;
   logic [127:0] exp_data[$];
   int           exp_addr[$];
   bit           exp_last[$];

   function automatic void add_drops(int n);
      m_drops = (m_drops + n > 65535) ? 65535 : m_drops + n;
   endfunction

   function automatic void model_clear();
      run_d.delete(); exp_data.delete(); exp_addr.delete(); exp_last.delete();
      m_drops = 0;
   endfunction

   function automatic void model_accept(int h, int v, logic [15:0] d);
      logic [127:0] w;
      if (run_d.size() > 0 && v == run_v && h == run_last_h + 1) begin
         run_d.push_back(d);
         run_last_h = h;
      end else begin
         add_drops(run_d.size());
         run_d.delete();
         if (h < H && v < V && h % 8 == 0) begin
            run_d.push_back(d);
            run_start_h = h; run_last_h = h; run_v = v;
         end else begin
            add_drops(1);
         end
      end
      if (run_d.size() == 8) begin
         w = '0;
         for (int i = 0; i < 8; i++) w[i*16 +: 16] = run_d[i];
         exp_data.push_back(w);
         exp_addr.push_back(((run_v * H + run_start_h) / 8) % (1 << 24));
         exp_last.push_back(run_v == V - 1 && run_last_h == H - 1);
         run_d.delete();
      end
   endfunction

   // Monitor: the value at a negedge is what the next posedge will act on.
   logic [127:0] s_data;
   logic [23:0]  s_addr;
   logic         s_last;
   bit           stalled = 0;

   always @(negedge clk) begin
      if (rst) begin
         model_clear();
         stalled = 0;
      end else begin
         n_checks++;
         if (drop_count !== 16'(m_drops)) begin
            n_fail++; $display("FAIL drop_count: got %0d want %0d", drop_count, m_drops);
         end
         if (chunk_tvalid) begin
            if (stalled) begin
               n_checks++;
               if ({chunk_tdata, chunk_taddr, chunk_tlast} !== {s_data, s_addr, s_last}) begin
                  n_fail++; $display("FAIL out_stable: got addr %0d want %0d", chunk_taddr, s_addr);
               end
            end
            if (chunk_tready) begin
               n_out++;
               n_checks++;
               if (exp_data.size() == 0) begin
                  n_fail++; $display("FAIL unexpected_chunk: got addr %0d, want none", chunk_taddr);
               end else begin
                  logic [127:0] ed; logic [23:0] ea; bit el;
                  ed = exp_data.pop_front(); ea = 24'(exp_addr.pop_front()); el = exp_last.pop_front();
                  if (chunk_tdata !== ed || chunk_taddr !== ea || chunk_tlast !== el) begin
                     n_fail++;
                     $display("FAIL chunk: got %h/%0d/%0b want %h/%0d/%0b",
                              chunk_tdata, chunk_taddr, chunk_tlast, ed, ea, el);
                  end
               end
               stalled = 0;
            end else begin
               stalled = 1;
               s_data = chunk_tdata; s_addr = chunk_taddr; s_last = chunk_tlast;
            end
         end else begin
            if (stalled) begin
               n_checks++; n_fail++;
               $display("FAIL valid_drop: got tvalid 0 want 1 (no handshake)");
            end
            stalled = 0;
         end
         if (pixel_tvalid && pixel_tready)
            model_accept(int'(pixel_h_count), int'(pixel_v_count), pixel_tdata);
      end
   end

   task automatic tick();
      @(posedge clk); #1;
      if (rand_ready) chunk_tready = ($urandom_range(0, 3) != 0);
   endtask

   task automatic send_pixel(input int h, input int v, input logic [15:0] d);
      bit acc;
      acc = 0;
      last_tries = 0;
      pixel_tvalid = 1; pixel_h_count = 11'(h); pixel_v_count = 10'(v); pixel_tdata = d;
      for (int i = 0; i < 64 && !acc; i++) begin
         @(negedge clk);
         acc = pixel_tready;
         last_tries++;
         tick();
      end
      pixel_tvalid = 0;
      n_checks++;
      if (!acc) begin
         n_fail++; $display("FAIL send_timeout: got no accept want accept (h=%0d v=%0d)", h, v);
      end
   endtask

   task automatic test_reset();
      rst = 1; pixel_tvalid = 0; chunk_tready = 1; rand_ready = 0;
      tick(); tick();
      n_checks++;
      if ({pixel_tready, chunk_tvalid, chunk_tlast, chunk_taddr, drop_count, chunk_tdata} !== '0) begin
         n_fail++;
         $display("FAIL reset_hold: got rdy %0b vld %0b addr %0d drops %0d want all 0",
                  pixel_tready, chunk_tvalid, chunk_taddr, drop_count);
      end
      rst = 0; #1;
      n_checks++;
      if (pixel_tready !== 1'b1) begin
         n_fail++; $display("FAIL reset_release_ready: got %0b want 1", pixel_tready);
      end
      tick();
   endtask

   task automatic test_first_chunk();
      test_reset();
      for (int k = 0; k < 8; k++) begin
         send_pixel(k, 0, 16'(k + 1));
         if (k == 6) begin
            n_checks++;
            if (chunk_tvalid !== 1'b0) begin
               n_fail++; $display("FAIL early_valid: got %0b want 0", chunk_tvalid);
            end
         end
      end
      n_checks++;
      if (chunk_tvalid !== 1'b1 || chunk_taddr !== 24'd0 || chunk_tlast !== 1'b0 ||
          chunk_tdata !== 128'h0008_0007_0006_0005_0004_0003_0002_0001) begin
         n_fail++;
         $display("FAIL first_chunk: got %0b/%0d/%0b/%h want 1/0/0/00080007000600050004000300020001",
                  chunk_tvalid, chunk_taddr, chunk_tlast, chunk_tdata);
      end
      tick();
   endtask

   task automatic test_last_chunk();
      logic [127:0] w;
      logic [15:0]  d;
      test_reset();
      for (int k = 0; k < 8; k++) begin
         d = 16'($urandom);
         w[k*16 +: 16] = d;
         send_pixel(1272 + k, 719, d);
      end
      n_checks++;
      if (chunk_tvalid !== 1'b1 || chunk_taddr !== 24'd115199 || chunk_tlast !== 1'b1 || chunk_tdata !== w) begin
         n_fail++;
         $display("FAIL last_chunk: got %0b/%0d/%0b want 1/115199/1", chunk_tvalid, chunk_taddr, chunk_tlast);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      int n0, stalls;
      test_reset();
      n0 = n_out; stalls = 0;
      for (int k = 0; k < 64; k++) begin
         send_pixel(k, 3, 16'($urandom));
         if (last_tries != 1) stalls++;
      end
      tick(); tick();
      n_checks++;
      if (stalls != 0 || n_out - n0 != 8) begin
         n_fail++; $display("FAIL back_to_back: got stalls %0d chunks %0d want 0 and 8", stalls, n_out - n0);
      end
   endtask

   task automatic test_backpressure();
      test_reset();
      for (int k = 0; k < 8; k++) send_pixel(k, 5, 16'($urandom));
      chunk_tready = 0;
      for (int k = 8; k < 16; k++) send_pixel(k, 5, 16'($urandom));
      n_checks++;
      if (pixel_tready !== 1'b0 || chunk_tvalid !== 1'b1 || chunk_taddr !== 24'd800) begin
         n_fail++;
         $display("FAIL hold_entry: got rdy %0b vld %0b addr %0d want 0/1/800", pixel_tready, chunk_tvalid, chunk_taddr);
      end
      pixel_tvalid = 1; pixel_h_count = 11'd16; pixel_v_count = 10'd5; pixel_tdata = 16'($urandom);
      tick();
      n_checks++;
      if (pixel_tready !== 1'b0) begin
         n_fail++; $display("FAIL hold_stall: got rdy %0b want 0", pixel_tready);
      end
      chunk_tready = 1;
      tick();
      chunk_tready = 0;
      n_checks++;
      if (pixel_tready !== 1'b1 || chunk_tvalid !== 1'b1 || chunk_taddr !== 24'd801) begin
         n_fail++;
         $display("FAIL hold_release: got rdy %0b vld %0b addr %0d want 1/1/801", pixel_tready, chunk_tvalid, chunk_taddr);
      end
      chunk_tready = 1;
      for (int k = 16; k < H; k++) send_pixel(k, 5, 16'($urandom));
      tick(); tick();
   endtask

   task automatic test_misalign();
      test_reset();
      for (int k = 0; k < 4; k++) send_pixel(k, 2, 16'($urandom));
      send_pixel(9, 2, 16'($urandom));
      n_checks++;
      if (drop_count !== 16'd5) begin
         n_fail++; $display("FAIL misalign_drops: got %0d want 5", drop_count);
      end
      for (int k = 16; k < 24; k++) send_pixel(k, 2, 16'($urandom));
      n_checks++;
      if (chunk_tvalid !== 1'b1 || chunk_taddr !== 24'((2 * H + 16) >> 3)) begin
         n_fail++; $display("FAIL misalign_chunk: got %0b/%0d want 1/%0d", chunk_tvalid, chunk_taddr, (2 * H + 16) >> 3);
      end
      tick();
   endtask

   task automatic test_bad_start();
      test_reset();
      send_pixel(3, 0, 16'h1234);
      send_pixel(1280, 0, 16'h2345);
      send_pixel(0, 720, 16'h3456);
      tick();
      n_checks++;
      if (drop_count !== 16'd3 || chunk_tvalid !== 1'b0) begin
         n_fail++; $display("FAIL bad_start: got drops %0d vld %0b want 3/0", drop_count, chunk_tvalid);
      end
   endtask

   task automatic test_reset_mid();
      logic [127:0] w;
      test_reset();
      send_pixel(3, 0, 16'h0bad);
      for (int k = 0; k < 5; k++) send_pixel(k, 1, 16'hdead);
      rst = 1; #1;
      n_checks++;
      if ({pixel_tready, chunk_tvalid, chunk_tlast, chunk_taddr, drop_count, chunk_tdata} !== '0) begin
         n_fail++; $display("FAIL reset_mid_fill: got drops %0d rdy %0b want 0/0", drop_count, pixel_tready);
      end
      tick(); rst = 0; tick();
      chunk_tready = 0;
      for (int k = 0; k < 8; k++) send_pixel(k, 1, 16'hbeef);
      rst = 1; #1;
      n_checks++;
      if ({pixel_tready, chunk_tvalid, chunk_tlast, chunk_taddr, drop_count, chunk_tdata} !== '0) begin
         n_fail++; $display("FAIL reset_mid_valid: got vld %0b addr %0d want 0/0", chunk_tvalid, chunk_taddr);
      end
      tick(); rst = 0; tick();
      chunk_tready = 1;
      for (int k = 0; k < 8; k++) begin
         w[k*16 +: 16] = 16'(16'ha0 + k);
         send_pixel(k, 4, 16'(16'ha0 + k));
      end
      n_checks++;
      if (chunk_tvalid !== 1'b1 || chunk_taddr !== 24'd640 || chunk_tdata !== w) begin
         n_fail++; $display("FAIL reset_fresh_chunk: got %0b/%0d/%h want 1/640/%h", chunk_tvalid, chunk_taddr, chunk_tdata, w);
      end
      tick();
   endtask

   task automatic test_random();
      int r, h, v, n;
      test_reset();
      rand_ready = 1;
      for (int it = 0; it < 250; it++) begin
         r = $urandom_range(0, 9);
         if (r < 7) begin
            v = $urandom_range(0, V - 1);
            h = 8 * $urandom_range(0, H / 8 - 1);
            n = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 8;
            for (int k = 0; k < n; k++) send_pixel(h + k, v, 16'($urandom));
         end else if (r < 9) begin
            send_pixel($urandom_range(0, 1295), $urandom_range(0, 725), 16'($urandom));
         end else begin
            repeat ($urandom_range(1, 4)) tick();
         end
      end
      rand_ready = 0;
      chunk_tready = 1;
      repeat (4) tick();
      n_checks++;
      if (exp_data.size() != 0 || chunk_tvalid !== 1'b0 || drop_count !== 16'(m_drops)) begin
         n_fail++;
         $display("FAIL random_drain: got pending %0d vld %0b drops %0d want 0/0/%0d",
                  exp_data.size(), chunk_tvalid, drop_count, m_drops);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_first_chunk();
      test_last_chunk();
      test_back_to_back();
      test_backpressure();
      test_misalign();
      test_bad_start();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
